// File: rtl/matmul_op_ctrl_if.sv
// Bundle of the control-register, calc-unit and scratchpad signals seen by
// the matrix-multiply operation controller. The master modport is the
// controller's view; the slave modport is the surrounding system's view.
interface matmul_op_ctrl_if #(
    parameter int SP_AW = 2
);
    logic             cfg_start_i;
    logic             cfg_mode_i;
    logic [2:0]       cfg_n_dim_i;
    logic [2:0]       cfg_k_dim_i;
    logic [2:0]       cfg_m_dim_i;
    logic [SP_AW-1:0] cfg_rd_target_i;
    logic [SP_AW-1:0] cfg_wr_target_i;
    logic             calc_start_o;
    logic             calc_mode_o;
    logic [2:0]       calc_n_dim_o;
    logic [2:0]       calc_k_dim_o;
    logic [2:0]       calc_m_dim_o;
    logic             calc_finish_i;
    logic             sp_re_o;
    logic [SP_AW-1:0] sp_rtarget_o;
    logic             sp_rvalid_i;
    logic             bias_load_o;
    logic             sp_we_o;
    logic [SP_AW-1:0] sp_wtarget_o;
    logic             clr_start_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [1:0]       err_code_o;

    modport master (
        input  cfg_start_i, cfg_mode_i, cfg_n_dim_i, cfg_k_dim_i, cfg_m_dim_i,
               cfg_rd_target_i, cfg_wr_target_i, calc_finish_i, sp_rvalid_i,
        output calc_start_o, calc_mode_o, calc_n_dim_o, calc_k_dim_o, calc_m_dim_o,
               sp_re_o, sp_rtarget_o, bias_load_o, sp_we_o, sp_wtarget_o,
               clr_start_o, busy_o, done_o, err_o, err_code_o
    );

    modport slave (
        output cfg_start_i, cfg_mode_i, cfg_n_dim_i, cfg_k_dim_i, cfg_m_dim_i,
               cfg_rd_target_i, cfg_wr_target_i, calc_finish_i, sp_rvalid_i,
        input  calc_start_o, calc_mode_o, calc_n_dim_o, calc_k_dim_o, calc_m_dim_o,
               sp_re_o, sp_rtarget_o, bias_load_o, sp_we_o, sp_wtarget_o,
               clr_start_o, busy_o, done_o, err_o, err_code_o
    );
endinterface

// File: rtl/matmul_op_ctrl.sv
// Sequencing controller for the matrix-multiply calc unit: accepts one
// request from the control register, validates dimensions, optionally loads
// the bias from scratchpad, runs the calc unit under a timeout, writes the
// result slot and hands the start bit back to the register file.
module matmul_op_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int SP_TARGETS  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic           clk_i,
    input logic           rst_ni,
    matmul_op_ctrl_if.master bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int SP_AW   = (SP_TARGETS > 1) ? $clog2(SP_TARGETS) : 1;
    localparam int CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Dimension fields are 3 bits, so any limit above 7 accepts every non-zero value.
    localparam logic [3:0]       MAX_DIM_C = (MAX_DIM > 7) ? 4'd8 : 4'(MAX_DIM);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_LOAD     = 3'd2,
        S_RUN      = 3'd3,
        S_WRITE    = 3'd4,
        S_FINISH   = 3'd5,
        S_WAIT_LOW = 3'd6
    } state_e;

    state_e           state_r, state_next_s;
    logic             mode_r;
    logic [2:0]       n_r, k_r, m_r;
    logic [SP_AW-1:0] rd_r, wr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic             calc_start_r, sp_re_r, sp_we_r, done_r, clr_start_r, busy_r;
    logic             accept_s, err_set_s, dims_ok_s, timeout_s;
    logic [1:0]       err_code_s;

    assign dims_ok_s = (n_r != 3'd0) && ({1'b0, n_r} <= MAX_DIM_C) &&
                       (k_r != 3'd0) && ({1'b0, k_r} <= MAX_DIM_C) &&
                       (m_r != 3'd0) && ({1'b0, m_r} <= MAX_DIM_C);
    assign timeout_s = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode plus request acceptance and error-event detection.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        err_set_s    = 1'b0;
        err_code_s   = 2'b00;
        case (state_r)
            S_IDLE: begin
                if (bus.cfg_start_i) begin
                    accept_s     = 1'b1;
                    state_next_s = S_CHECK;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!dims_ok_s) begin
                    err_set_s    = 1'b1;
                    err_code_s   = 2'b01;
                    state_next_s = S_FINISH;
                end else if (mode_r) begin
                    state_next_s = S_LOAD;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_LOAD: begin
                if (bus.sp_rvalid_i) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_LOAD;
                end
            end
            S_RUN: begin
                // A finish arriving in the timeout cycle still completes normally.
                if (bus.calc_finish_i) begin
                    state_next_s = S_WRITE;
                end else if (timeout_s) begin
                    err_set_s    = 1'b1;
                    err_code_s   = 2'b10;
                    state_next_s = S_FINISH;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_WRITE:  state_next_s = S_FINISH;
            S_FINISH: state_next_s = S_WAIT_LOW;
            S_WAIT_LOW: begin
                // A start bit left high must be seen low before a new request counts.
                if (!bus.cfg_start_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT_LOW;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Latch the request on acceptance so later register writes cannot disturb it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_r <= 1'b0;
            n_r    <= 3'd0;
            k_r    <= 3'd0;
            m_r    <= 3'd0;
            rd_r   <= '0;
            wr_r   <= '0;
        end else if (accept_s) begin
            mode_r <= bus.cfg_mode_i;
            n_r    <= bus.cfg_n_dim_i;
            k_r    <= bus.cfg_k_dim_i;
            m_r    <= bus.cfg_m_dim_i;
            rd_r   <= bus.cfg_rd_target_i;
            wr_r   <= bus.cfg_wr_target_i;
        end
    end

    // RUN-cycle counter; restarts from zero on every entry into RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (state_r == S_RUN) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Sticky error flag and code; a newly accepted request clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else if (accept_s) begin
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else if (err_set_s) begin
            err_r      <= 1'b1;
            err_code_r <= err_code_s;
        end
    end

    // Strobes registered from the next state so they align with the state they mark.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            calc_start_r <= 1'b0;
            sp_re_r      <= 1'b0;
            sp_we_r      <= 1'b0;
            done_r       <= 1'b0;
            clr_start_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            calc_start_r <= (state_next_s == S_RUN);
            sp_re_r      <= (state_next_s == S_LOAD);
            sp_we_r      <= (state_next_s == S_WRITE);
            done_r       <= (state_next_s == S_FINISH);
            clr_start_r  <= (state_next_s == S_FINISH);
            busy_r       <= (state_next_s != S_IDLE);
        end
    end

    assign bus.calc_start_o = calc_start_r;
    assign bus.calc_mode_o  = mode_r;
    assign bus.calc_n_dim_o = n_r;
    assign bus.calc_k_dim_o = k_r;
    assign bus.calc_m_dim_o = m_r;
    assign bus.sp_re_o      = sp_re_r;
    assign bus.sp_rtarget_o = rd_r;
    // Bias data is only valid in the rvalid cycle, so the capture strobe is combinational.
    assign bus.bias_load_o  = (state_r == S_LOAD) && bus.sp_rvalid_i;
    assign bus.sp_we_o      = sp_we_r;
    assign bus.sp_wtarget_o = wr_r;
    assign bus.clr_start_o  = clr_start_r;
    assign bus.busy_o       = busy_r;
    assign bus.done_o       = done_r;
    assign bus.err_o        = err_r;
    assign bus.err_code_o   = err_code_r;
endmodule

// File: tb/tb_matmul_op_ctrl.sv
// Directed bench for matmul_op_ctrl with a write-target scoreboard.
module tb_matmul_op_ctrl;
    localparam int SP_AW = 2;
    localparam int TO    = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_op_ctrl_if #(.SP_AW(SP_AW)) bus ();

    matmul_op_ctrl #(
        .DATA_WIDTH(8), .BUS_WIDTH(16), .SP_TARGETS(4), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_wr_q[$];

    int r_start_first, r_start_cnt, r_re_first, r_rtarget, r_bias_t, r_bias_cnt;
    int r_we_t, r_we_cnt, r_done_t, r_clr_t, r_err_done, r_code_done, r_err_t1, r_ndim;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({bus.calc_start_o, bus.calc_mode_o, bus.calc_n_dim_o, bus.calc_k_dim_o,
                     bus.calc_m_dim_o, bus.sp_re_o, bus.sp_rtarget_o, bus.bias_load_o,
                     bus.sp_we_o, bus.sp_wtarget_o, bus.clr_start_o, bus.busy_o,
                     bus.done_o, bus.err_o, bus.err_code_o});
    endfunction

    // Scoreboard: every write strobe must match the oldest expected target.
    always @(negedge clk) begin
        if (rst_n && bus.sp_we_o) begin
            check("we_expected", int'(exp_wr_q.size() != 0), 1);
            if (exp_wr_q.size() != 0) begin
                check("we_target", int'(bus.sp_wtarget_o), exp_wr_q.pop_front());
            end
        end
    end

    // Runs one request starting at a negedge; t counts negedges from the start drive.
    task automatic run_op(input logic mode, input logic [2:0] n, input logic [2:0] k,
                          input logic [2:0] m, input logic [1:0] rd, input logic [1:0] wr,
                          input int fin_delay, input int rv_delay, input bit hold,
                          input bit exp_write);
        r_start_first = -1; r_start_cnt = 0; r_re_first = -1; r_rtarget = -1;
        r_bias_t = -1; r_bias_cnt = 0; r_we_t = -1; r_we_cnt = 0; r_done_t = -1;
        r_clr_t = -1; r_err_done = -1; r_code_done = -1; r_err_t1 = -1; r_ndim = -1;
        bus.cfg_mode_i = mode; bus.cfg_n_dim_i = n; bus.cfg_k_dim_i = k;
        bus.cfg_m_dim_i = m; bus.cfg_rd_target_i = rd; bus.cfg_wr_target_i = wr;
        bus.cfg_start_i = 1'b1;
        if (exp_write) exp_wr_q.push_back(int'(wr));
        for (int t = 0; t < 300; t++) begin
            if (t > 0) @(negedge clk);
            if (bus.calc_start_o) begin
                if (r_start_first < 0) begin
                    r_start_first = t;
                    r_ndim = int'(bus.calc_n_dim_o);
                end
                r_start_cnt++;
            end
            if (bus.sp_re_o && r_re_first < 0) begin
                r_re_first = t;
                r_rtarget = int'(bus.sp_rtarget_o);
            end
            if (bus.sp_we_o) begin r_we_t = t; r_we_cnt++; end
            if (bus.clr_start_o) r_clr_t = t;
            if (bus.done_o) begin
                r_done_t = t;
                r_err_done = int'(bus.err_o);
                r_code_done = int'(bus.err_code_o);
            end
            if (t == 1) begin
                r_err_t1 = int'(bus.err_o);
                // Scramble the live request; the latched copy must be used.
                bus.cfg_n_dim_i = 3'd7; bus.cfg_k_dim_i = 3'd7; bus.cfg_m_dim_i = 3'd7;
                bus.cfg_wr_target_i = ~wr; bus.cfg_rd_target_i = ~rd;
            end
            bus.sp_rvalid_i = (r_re_first >= 0 && t == r_re_first + rv_delay);
            bus.calc_finish_i = (fin_delay >= 0 && r_start_first >= 0 &&
                                 t == r_start_first + fin_delay);
            if (bus.clr_start_o && !hold) bus.cfg_start_i = 1'b0;
            #1;
            if (bus.bias_load_o) begin r_bias_t = t; r_bias_cnt++; end
            if (r_done_t >= 0 && t >= r_done_t + 2) break;
        end
        bus.sp_rvalid_i = 1'b0;
        bus.calc_finish_i = 1'b0;
        check("op_done_seen", int'(r_done_t >= 0), 1);
    endtask

    initial begin
        int bad;
        bus.cfg_start_i = 1'b0; bus.cfg_mode_i = 1'b0; bus.cfg_n_dim_i = 3'd0;
        bus.cfg_k_dim_i = 3'd0; bus.cfg_m_dim_i = 3'd0; bus.cfg_rd_target_i = 2'd0;
        bus.cfg_wr_target_i = 2'd0; bus.calc_finish_i = 1'b0; bus.sp_rvalid_i = 1'b0;
        #1;
        check("reset_outputs", outs_vec(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", outs_vec(), 0);

        // mode 0, 2x2x2, finish 3 cycles after calc start
        run_op(1'b0, 3'd2, 3'd2, 3'd2, 2'd0, 2'd3, 3, 0, 1'b0, 1'b1);
        check("m0_start_lat", r_start_first, 2);
        check("m0_latched_n", r_ndim, 2);
        check("m0_start_cnt", r_start_cnt, 4);
        check("m0_we_t", r_we_t, r_start_first + 4);
        check("m0_we_cnt", r_we_cnt, 1);
        check("m0_done_t", r_done_t, r_we_t + 1);
        check("m0_clr_t", r_clr_t, r_done_t);
        check("m0_err", r_err_done, 0);
        check("m0_re_none", r_re_first, -1);

        // mode 1, bias from slot 1, rvalid 2 cycles after read strobe
        @(negedge clk);
        run_op(1'b1, 3'd1, 3'd2, 3'd1, 2'd1, 2'd2, 1, 2, 1'b0, 1'b1);
        check("m1_re_t", r_re_first, 2);
        check("m1_rtarget", r_rtarget, 1);
        check("m1_bias_t", r_bias_t, r_re_first + 2);
        check("m1_bias_cnt", r_bias_cnt, 1);
        check("m1_start_after_bias", r_start_first, r_bias_t + 1);
        check("m1_we_cnt", r_we_cnt, 1);
        check("m1_we_t", r_we_t, r_start_first + 2);
        check("m1_err", r_err_done, 0);

        // bad dimension n=3
        @(negedge clk);
        run_op(1'b0, 3'd3, 3'd1, 3'd1, 2'd0, 2'd1, 0, 0, 1'b0, 1'b0);
        check("badn_start_cnt", r_start_cnt, 0);
        check("badn_we_cnt", r_we_cnt, 0);
        check("badn_done_t", r_done_t, 2);
        check("badn_clr_t", r_clr_t, 2);
        check("badn_err", r_err_done, 1);
        check("badn_code", r_code_done, 1);

        // bad dimension k=0; previous error must be cleared on acceptance
        @(negedge clk);
        run_op(1'b1, 3'd1, 3'd0, 3'd2, 2'd0, 2'd1, 0, 0, 1'b0, 1'b0);
        check("badk_err_t1", r_err_t1, 0);
        check("badk_start_cnt", r_start_cnt, 0);
        check("badk_re_none", r_re_first, -1);
        check("badk_code", r_code_done, 1);

        // timeout: finish never arrives
        @(negedge clk);
        run_op(1'b0, 3'd2, 3'd1, 3'd2, 2'd0, 2'd2, -1, 0, 1'b0, 1'b0);
        check("to_start_cnt", r_start_cnt, TO);
        check("to_we_cnt", r_we_cnt, 0);
        check("to_done_t", r_done_t, r_start_first + TO);
        check("to_err", r_err_done, 1);
        check("to_code", r_code_done, 2);

        // next valid start clears the error; start bit then held high
        @(negedge clk);
        run_op(1'b0, 3'd1, 3'd1, 3'd1, 2'd0, 2'd1, 0, 0, 1'b1, 1'b1);
        check("clr_err_t1", r_err_t1, 0);
        check("clr_err_done", r_err_done, 0);
        check("clr_code_done", r_code_done, 0);
        check("clr_we_cnt", r_we_cnt, 1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b1 || bus.calc_start_o !== 1'b0 || bus.done_o !== 1'b0) bad++;
        end
        check("hold_no_retrigger", bad, 0);
        bus.cfg_start_i = 1'b0;
        @(negedge clk);
        check("hold_released_idle", int'(bus.busy_o), 0);
        run_op(1'b0, 3'd2, 3'd2, 3'd1, 2'd0, 2'd0, 0, 0, 1'b0, 1'b1);
        check("reraise_start_lat", r_start_first, 2);
        check("reraise_we_cnt", r_we_cnt, 1);

        // reset in the middle of RUN
        @(negedge clk);
        bus.cfg_mode_i = 1'b0; bus.cfg_n_dim_i = 3'd2; bus.cfg_k_dim_i = 3'd2;
        bus.cfg_m_dim_i = 3'd2; bus.cfg_wr_target_i = 2'd3; bus.cfg_start_i = 1'b1;
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.calc_start_o) begin bad = 0; break; end
        end
        check("rst_run_reached", bad, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", outs_vec(), 0);
        bus.cfg_start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.calc_finish_i = 1'b1;
        @(negedge clk);
        bus.calc_finish_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.sp_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) bad++;
        end
        check("rst_no_spurious", bad, 0);
        check("scoreboard_empty", exp_wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
